// File: rtl/noc_router_pkg.sv
// Shared port indices, flit header layout and XY route helper for the mesh routers.
package noc_router_pkg;

    localparam int NUM_PORTS = 5;

    localparam logic [2:0] P_N = 3'd0;
    localparam logic [2:0] P_S = 3'd1;
    localparam logic [2:0] P_E = 3'd2;
    localparam logic [2:0] P_W = 3'd3;
    localparam logic [2:0] P_L = 3'd4;

    localparam int DEST_X_MSB = 7;
    localparam int DEST_X_LSB = 4;
    localparam int DEST_Y_MSB = 3;
    localparam int DEST_Y_LSB = 0;

    // Dimension-order routing: resolve X fully before Y.
    function automatic logic [2:0] xy_route(input logic [3:0] destx, input logic [3:0] desty,
                                            input logic [3:0] x, input logic [3:0] y);
        if (destx > x) return P_E;
        if (destx < x) return P_W;
        if (desty > y) return P_N;
        if (desty < y) return P_S;
        return P_L;
    endfunction

endpackage

// File: rtl/router_in_fifo.sv
// Per-input flit buffer: circular store with wrap-bit pointers; a pop frees room for a same-cycle write.
module router_in_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full,
    output logic              overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_rd;
    logic              do_wr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd    = rd_en && !empty;
    assign do_wr    = wr_en && (!full || do_rd);
    assign overflow = wr_en && full && !do_rd;
    assign head     = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/mesh_router_param.sv
// Five-port XY mesh router with presence mask, per-output round robin and credit flow control.
// Optional per-output flit counters are enabled by defining ROUTER_STATS_EN.
module mesh_router_param
    import noc_router_pkg::*;
#(
    parameter int         XCOORD     = 0,
    parameter int         YCOORD     = 0,
    parameter int         DATA_W     = 16,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [4:0] PORT_MASK  = 5'b11111
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
    input  logic [NUM_PORTS-1:0]          in_valid,
    output logic [NUM_PORTS-1:0]          in_credit_o,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data,
    output logic [NUM_PORTS-1:0]          out_valid,
    input  logic [NUM_PORTS-1:0]          out_credit_i,
    output logic [1:0]                    err_o
`ifdef ROUTER_STATS_EN
    ,
    output logic [NUM_PORTS*16-1:0]       stat_flits_o
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0]    head      [NUM_PORTS];
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] ovf;
    logic [NUM_PORTS-1:0] unused_full;
    logic [2:0]           route     [NUM_PORTS];
    logic [NUM_PORTS-1:0] drop;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] gnt       [NUM_PORTS];
    logic [NUM_PORTS-1:0] send;
    logic [DATA_W-1:0]    send_data [NUM_PORTS];
    logic [CW-1:0]        credit    [NUM_PORTS];
    logic [2:0]           ptr       [NUM_PORTS];
    logic [2:0]           ptr_next  [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        if (PORT_MASK[p]) begin : g_fifo
            router_in_fifo #(
                .DATA_W     (DATA_W),
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk      (clk),
                .rst      (rst),
                .wr_en    (in_valid[p]),
                .wr_data  (in_data[p*DATA_W +: DATA_W]),
                .rd_en    (pop[p]),
                .head     (head[p]),
                .empty    (empty[p]),
                .full     (unused_full[p]),
                .overflow (ovf[p])
            );
        end else begin : g_absent
            assign head[p]        = '0;
            assign empty[p]       = 1'b1;
            assign unused_full[p] = 1'b0;
            assign ovf[p]         = 1'b0;
        end
    end

    // Heads routed to an absent port, or turned back where they came from, are discarded.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            route[p] = xy_route(head[p][DEST_X_MSB:DEST_X_LSB], head[p][DEST_Y_MSB:DEST_Y_LSB],
                                4'(XCOORD), 4'(YCOORD));
            drop[p]  = !empty[p] && (!PORT_MASK[route[p]] || (route[p] == 3'(p) && 3'(p) != P_L));
        end
    end

    // NOTE: every combinational output gets a default before the search loop, so no latches form.
    always_comb begin
        int idx;
        idx = 0;
        for (int q = 0; q < NUM_PORTS; q++) begin
            gnt[q]      = '0;
            ptr_next[q] = ptr[q];
        end
        for (int q = 0; q < NUM_PORTS; q++) begin
            if (PORT_MASK[q] && credit[q] != '0) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    idx = int'(ptr[q]) + k;
                    if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
                    if (gnt[q] == '0 && !empty[idx] && !drop[idx] && route[idx] == 3'(q)) begin
                        gnt[q][idx] = 1'b1;
                        ptr_next[q] = (idx == NUM_PORTS - 1) ? 3'd0 : 3'(idx + 1);
                    end
                end
            end
        end
    end

    always_comb begin
        pop = drop;
        for (int q = 0; q < NUM_PORTS; q++) begin
            send[q]      = |gnt[q];
            send_data[q] = '0;
            for (int g = 0; g < NUM_PORTS; g++) begin
                if (gnt[q][g]) send_data[q] = head[g];
                pop[g] = pop[g] | gnt[q][g];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= '0;
            out_data    <= '0;
            in_credit_o <= '0;
            err_o       <= '0;
            for (int q = 0; q < NUM_PORTS; q++) begin
                credit[q] <= CW'(FIFO_DEPTH);
                ptr[q]    <= '0;
            end
        end else begin
            out_valid   <= send & PORT_MASK;
            in_credit_o <= pop & PORT_MASK;
            err_o       <= err_o | {|drop, |ovf};
            for (int q = 0; q < NUM_PORTS; q++) begin
                if (send[q]) out_data[q*DATA_W +: DATA_W] <= send_data[q];
                ptr[q] <= ptr_next[q];
                if (PORT_MASK[q]) begin
                    if (send[q] && !out_credit_i[q])
                        credit[q] <= credit[q] - CW'(1);
                    else if (!send[q] && out_credit_i[q] && credit[q] != CW'(FIFO_DEPTH))
                        credit[q] <= credit[q] + CW'(1);
                end
            end
        end
    end

`ifdef ROUTER_STATS_EN
    logic [15:0] stat_cnt [NUM_PORTS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int q = 0; q < NUM_PORTS; q++) stat_cnt[q] <= '0;
        end else begin
            for (int q = 0; q < NUM_PORTS; q++)
                if (out_valid[q] && stat_cnt[q] != 16'hFFFF) stat_cnt[q] <= stat_cnt[q] + 16'd1;
        end
    end

    always_comb begin
        for (int q = 0; q < NUM_PORTS; q++) stat_flits_o[q*16 +: 16] = stat_cnt[q];
    end
`endif

endmodule

// File: doc/mesh_router_param.md
Name: mesh_router_param

Overview:
- Parametrised five-port mesh router; next generation of the fixed-width edge/corner routers.
- Each port is enabled by a presence mask, so one module covers interior, edge and corner tiles.
- Single-flit packets; per-input FIFO buffering, XY dimension-order routing, per-output round-robin arbitration, credit-based flow control.
- Instantiated once per tile in the mesh top; the local (L) port connects to the tile's network interface.

Parameters:
XCOORD, 0, tile X coordinate (0..15)
YCOORD, 0, tile Y coordinate (0..15)
DATA_W, 16, flit width; bits [7:4] = dest X, [3:0] = dest Y; must be >= 8
FIFO_DEPTH, 4, input FIFO entries per port; power of two, >= 2
PORT_MASK, 5'b11111, port present bits, index order 0=N 1=S 2=E 3=W 4=L; L must be set

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_data  in  5*DATA_W  flit from upstream, port p at [p*DATA_W +: DATA_W]
in_valid  in  5  write strobe per input port
in_credit_o  out  5  one-cycle pulse to upstream per flit popped from that input FIFO
out_data  out  5*DATA_W  registered flit to downstream
out_valid  out  5  registered send strobe per output port
out_credit_i  in  5  one-cycle credit return pulse from downstream per output port
err_o  out  2  sticky: [0] input overflow, [1] misroute drop

Behaviour:
- Reset (async, rst=1): FIFOs empty; out_valid=0, out_data=0, in_credit_o=0, err_o=0; credit counters = FIFO_DEPTH; RR pointers = 0.
- Absent ports (PORT_MASK bit 0): in_valid ignored, FIFO never written; out_valid, out_data and in_credit_o tied 0.
- Input FIFO: write on in_valid when not full. Write while full drops the flit and sets err_o[0]. Simultaneous pop and write on a full FIFO is legal.
- Route compute on FIFO head, XY order:
  - dest X > XCOORD -> E; dest X < XCOORD -> W.
  - Otherwise dest Y > YCOORD -> N; dest Y < YCOORD -> S.
  - Otherwise L.
- Computed output absent in PORT_MASK: head popped without send, credit still returned, err_o[1] set.
- Requests: input p requests output q when its FIFO is non-empty, route = q, and credit[q] > 0. A U-turn (q == p, p != L) is treated as a misroute drop.
- Arbitration: per output, round-robin over the 5 inputs, starting at ptr[q]. On grant to input g, ptr[q] <= (g+1) mod 5; pointer holds when there is no grant. Each input routes to one output, so at most one grant per input per cycle.
- On grant, same cycle:
  - input FIFO pops;
  - next cycle: out_data[q] <= flit, out_valid[q] <= 1, in_credit_o[g] <= 1;
  - credit[q] decrements.
- Credit counter: width clog2(FIFO_DEPTH+1); saturating.
  - Send and out_credit_i in the same cycle: counter unchanged.
  - Increment at FIFO_DEPTH is ignored (no wrap).
- Latency: flit with in_valid at cycle t is at FIFO head at t+1, granted at t+1, out_valid at t+2 (zero-load, 2 cycles).
- Throughput: one flit per output per cycle while credits remain.
- Reset mid-operation: in-flight flits discarded; credits reinitialised (the whole mesh shares rst).

Optional Feature:
- Macro: ROUTER_STATS_EN.
- Defined: adds output stat_flits_o (5*16). Per output port, a 16-bit counter increments on each out_valid and saturates at 16'hFFFF; cleared by rst.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package noc_router_pkg:
  - port index constants P_N=0, P_S=1, P_E=2, P_W=3, P_L=4 and NUM_PORTS=5;
  - flit header field positions (DEST_X_MSB/LSB, DEST_Y_MSB/LSB);
  - function xy_route(destx, desty, x, y) returning a port index.
- Sub-module router_in_fifo (DATA_W, FIFO_DEPTH): circular buffer with wr/rd pointers plus a wrap bit. Provides head, empty, full and overflow outputs; the top generates 5 instances gated by PORT_MASK.

Test Plan:
- XCOORD=1, YCOORD=1, single flit 16'h00_21 on L at t -> out_valid[E]=1 with 16'h0021 at t+2; in_credit_o[L] pulses at t+2; err_o=0.
- N, S and W all send dest (1,1) every cycle -> L out grants rotate N, S, W, N, ... one per cycle; no starvation over 30 cycles.
- Downstream E never returns credits; send 6 flits to E with FIFO_DEPTH=4 -> exactly 4 out_valid[E]. The rest stall in the L FIFO; one out_credit_i[E] pulse releases exactly one more.
- PORT_MASK=5'b11011 (E absent); flit to dest X > XCOORD from L -> no out_valid, err_o[1]=1, in_credit_o[L] pulses.
- Five in_valid writes to N with no grants possible (L out has no credits) -> 5th write dropped, err_o[0]=1. Assert rst mid-stream -> all outputs 0 immediately, credits back to 4.
- With ROUTER_STATS_EN: 70000 flits to L -> stat_flits_o[L] = 16'hFFFF (saturated).
